// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared next-PC source encoding and default reset vector for pc_gen
package pc_pkg;

    typedef enum logic [2:0] {
        SRC_EXC  = 3'd0,
        SRC_BR   = 3'd1,
        SRC_HOLD = 3'd2,
        SRC_RAS  = 3'd3,
        SRC_JMP  = 3'd4,
        SRC_SEQ  = 3'd5
    } pc_src_e;

    localparam int unsigned PC_AW_DEFAULT = 30;
    localparam logic [PC_AW_DEFAULT-1:0] PC_RESET_VEC = 30'h0000C00;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; full pushes overwrite the oldest entry
module pc_ras #(
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned AW        = 30
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [AW-1:0] push_data_i,
    output logic [AW-1:0] top_o,
    output logic          empty_o
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0] top_q, top_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr;

    assign wr_ptr  = top_q + PW'(1);
    assign top_o   = mem_q[top_q];
    assign empty_o = (count_q == '0);

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push_i) begin
            top_d = wr_ptr;
            // Count saturates; the pointer keeps wrapping so the oldest slot is reused.
            if (count_q != CW'(RAS_DEPTH)) begin
                count_d = count_q + CW'(1);
            end
        end else if (pop_i && !empty_o) begin
            top_d   = top_q - PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage PC with prioritised redirects, stall, start pulse; RAS under PC_RAS_EN
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned    AW        = 30,
    parameter logic [AW-1:0]  RESET_VEC = AW'(PC_RESET_VEC),
    parameter int unsigned    RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pc_we,
    input  logic          exc_valid,
    input  logic [AW-1:0] exc_target,
    input  logic          br_valid,
    input  logic [AW-1:0] br_target,
    input  logic          jmp_valid,
    input  logic [AW-1:0] jmp_target,
    input  logic          fetch_call,
    input  logic          fetch_ret,
    output logic [AW-1:0] pc,
    output logic          pc_valid,
    output logic          pc_start,
    output logic          ras_empty
);

    logic [AW-1:0] pc_q, pc_d;
    logic          valid_q;
    logic          start_q;
    logic [AW-1:0] pc_plus1;
    logic [AW-1:0] ras_top;
    logic          ras_empty_w;
    logic          ras_pop;
    pc_src_e       src;

    assign pc_plus1 = pc_q + AW'(1);

`ifdef PC_RAS_EN
    logic ras_push;
    logic ras_flush;

    // Exceptions and branch fix-ups squash the fetch, so they block stack updates.
    assign ras_pop   = valid_q && pc_we && fetch_ret && !exc_valid && !br_valid && !ras_empty_w;
    assign ras_push  = valid_q && pc_we && fetch_call && !fetch_ret && !exc_valid && !br_valid;
    assign ras_flush = valid_q && exc_valid;

    pc_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .AW        (AW)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .flush_i     (ras_flush),
        .push_data_i (pc_plus1),
        .top_o       (ras_top),
        .empty_o     (ras_empty_w)
    );
`else
    logic unused_ras_inputs;

    assign unused_ras_inputs = fetch_call ^ fetch_ret;
    assign ras_pop           = 1'b0;
    assign ras_top           = '0;
    assign ras_empty_w       = 1'b1;
`endif

    always_comb begin
        src = SRC_SEQ;
        if (exc_valid) begin
            src = SRC_EXC;
        end else if (br_valid) begin
            src = SRC_BR;
        end else if (!pc_we) begin
            src = SRC_HOLD;
        end else if (ras_pop) begin
            src = SRC_RAS;
        end else if (jmp_valid) begin
            src = SRC_JMP;
        end
    end

    always_comb begin
        pc_d = pc_plus1;
        case (src)
            SRC_EXC:  pc_d = exc_target;
            SRC_BR:   pc_d = br_target;
            SRC_HOLD: pc_d = pc_q;
            SRC_RAS:  pc_d = ras_top;
            SRC_JMP:  pc_d = jmp_target;
            SRC_SEQ:  pc_d = pc_plus1;
            default:  pc_d = pc_plus1;
        endcase
    end

    // The first edge after reset only makes RESET_VEC live; advancing starts on the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            valid_q <= 1'b1;
            start_q <= !valid_q;
            if (valid_q) begin
                pc_q <= pc_d;
            end
        end
    end

    assign pc        = pc_q;
    assign pc_valid  = valid_q;
    assign pc_start  = start_q;
    assign ras_empty = ras_empty_w;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - randomized bench for pc_gen against a queue-based next-PC model
module tb_pc_gen;

    localparam int unsigned AW    = 30;
    localparam int unsigned DEPTH = 4;
    localparam logic [AW-1:0] RV  = 30'h0000C00;

    logic          clk = 1'b0;
    logic          reset;
    logic          pc_we;
    logic          exc_valid, br_valid, jmp_valid;
    logic [AW-1:0] exc_target, br_target, jmp_target;
    logic          fetch_call, fetch_ret;
    logic [AW-1:0] pc;
    logic          pc_valid, pc_start, ras_empty;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [AW-1:0] m_pc;
    logic          m_valid, m_start;
    logic [AW-1:0] m_ras [$];

    always #5 clk = ~clk;

    pc_gen #(.AW(AW), .RESET_VEC(RV), .RAS_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_we      (pc_we),
        .exc_valid  (exc_valid),
        .exc_target (exc_target),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .fetch_call (fetch_call),
        .fetch_ret  (fetch_ret),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .pc_start   (pc_start),
        .ras_empty  (ras_empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: RAS is a plain list of return addresses, newest at the back.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc    = RV;
            m_valid = 1'b0;
            m_start = 1'b0;
            m_ras.delete();
        end else if (!m_valid) begin
            m_valid = 1'b1;
            m_start = 1'b1;
        end else begin
            m_start = 1'b0;
            if (exc_valid) begin
                m_pc = exc_target;
                m_ras.delete();
            end else if (br_valid) begin
                m_pc = br_target;
            end else if (pc_we) begin
`ifdef PC_RAS_EN
                if (fetch_ret && m_ras.size() > 0) begin
                    m_pc = m_ras.pop_back();
                end else begin
                    if (fetch_call && !fetch_ret) begin
                        m_ras.push_back(m_pc + 1);
                        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                    end
                    m_pc = jmp_valid ? jmp_target : m_pc + 1;
                end
`else
                m_pc = jmp_valid ? jmp_target : m_pc + 1;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", 32'(pc), 32'(m_pc));
            check("pc_valid", 32'(pc_valid), 32'(m_valid));
            check("pc_start", 32'(pc_start), 32'(m_start));
            check("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
        end
    end

    task automatic idle();
        pc_we = 1'b1; exc_valid = 1'b0; br_valid = 1'b0; jmp_valid = 1'b0;
        fetch_call = 1'b0; fetch_ret = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        idle();
        exc_target = '0; br_target = '0; jmp_target = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_pc", 32'(pc), 32'h00000C00);
        check("reset_valid", 32'(pc_valid), 32'd0);
        check("reset_empty", 32'(ras_empty), 32'd1);
        reset = 1'b0;
        chk_en = 1'b1;

        step();
        check("edge1_start", 32'(pc_start), 32'd1);
        check("edge1_pc", 32'(pc), 32'h00000C00);
        step();
        check("edge2_pc", 32'(pc), 32'h00000C01);
        check("edge2_start", 32'(pc_start), 32'd0);
        repeat (4) step();
        check("seq_pc", 32'(pc), 32'h00000C05);

        pc_we = 1'b0;
        repeat (3) step();
        check("stall_hold", 32'(pc), 32'h00000C05);
        br_valid = 1'b1; br_target = 30'h2000;
        step();
        check("br_in_stall", 32'(pc), 32'h00002000);
        idle();

        fetch_call = 1'b1;
        repeat (2) step();
        idle();
        exc_valid = 1'b1; exc_target = 30'h100;
        br_valid = 1'b1; br_target = 30'h200;
        jmp_valid = 1'b1; jmp_target = 30'h300;
        step();
        check("exc_prio", 32'(pc), 32'h00000100);
        check("exc_ras_empty", 32'(ras_empty), 32'd1);
        idle();

        jmp_valid = 1'b1; jmp_target = 30'h3FFFFFFF;
        step();
        idle();
        step();
        check("wrap", 32'(pc), 32'h00000000);

`ifdef PC_RAS_EN
        jmp_valid = 1'b1; jmp_target = 30'h10;
        step();
        for (int i = 2; i <= 6; i++) begin
            fetch_call = 1'b1; jmp_valid = 1'b1; jmp_target = AW'(i * 16);
            step();
        end
        idle();
        fetch_ret = 1'b1;
        step(); check("ret1", 32'(pc), 32'h51);
        step(); check("ret2", 32'(pc), 32'h41);
        step(); check("ret3", 32'(pc), 32'h31);
        step(); check("ret4", 32'(pc), 32'h21);
        step(); check("ret_empty", 32'(pc), 32'h22);
        idle();
`endif

        for (int n = 0; n < 2000; n++) begin
            pc_we      = ($urandom_range(0, 9) != 0);
            exc_valid  = ($urandom_range(0, 30) == 0);
            br_valid   = ($urandom_range(0, 12) == 0);
            jmp_valid  = ($urandom_range(0, 6) == 0);
            fetch_call = ($urandom_range(0, 4) == 0);
            fetch_ret  = ($urandom_range(0, 4) == 0);
            exc_target = AW'($urandom());
            br_target  = AW'($urandom());
            jmp_target = ($urandom_range(0, 9) == 0) ? '1 : AW'($urandom());
            if ($urandom_range(0, 150) == 0) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
            step();
        end

        idle();
        jmp_valid = 1'b1; jmp_target = 30'h5555;
        #2 reset = 1'b1;
        #1;
        check("async_pc", 32'(pc), 32'h00000C00);
        check("async_valid", 32'(pc_valid), 32'd0);
        check("async_start", 32'(pc_start), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle();
        step();
        check("post_reset_start", 32'(pc_start), 32'd1);
        step();
        check("post_reset_pc", 32'(pc), 32'h00000C01);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
